// File: rtl/leaf_stream_fifo.sv
// Single-clock stream FIFO with registered-count flow control.
// Ready/valid are derived only from the stored count, so out_ready never reaches in_ready combinationally.
module leaf_stream_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  input  logic [WIDTH-1:0]         in_data,
  output logic                     in_ready,
  output logic                     out_valid,
  output logic [WIDTH-1:0]         out_data,
  input  logic                     out_ready,
  output logic [$clog2(DEPTH):0]   count,
  output logic [15:0]              xfer_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic             push, pop;

  assign in_ready  = (count != FULL_CNT);
  assign out_valid = (count != '0);
  assign out_data  = mem[rd_ptr];
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  // Power-of-two depth lets the pointers wrap by natural overflow.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      xfer_cnt <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) begin
        rd_ptr   <= rd_ptr + 1'b1;
        xfer_cnt <= xfer_cnt + 16'd1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (push && !rst) mem[wr_ptr] <= in_data;
  end

endmodule

// File: doc/leaf_stream_fifo.md
LEAF_STREAM_FIFO -- requirements
Module: leaf_stream_fifo

Interface
REQ-001 SHALL have parameter WIDTH, default 8, giving the data word width in bits.
REQ-002 SHALL have parameter DEPTH, default 4, giving the entry count; legal values are powers of two, 2 to 16.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 SHALL have port in_valid, input, 1 bit: the upstream word is present.
REQ-006 SHALL have port in_data, input, WIDTH bits: the upstream word.
REQ-007 SHALL have port in_ready, output, 1 bit: the block accepts the word this cycle.
REQ-008 SHALL have port out_valid, output, 1 bit: out_data holds the oldest stored word.
REQ-009 SHALL have port out_data, output, WIDTH bits: the oldest stored word.
REQ-010 SHALL have port out_ready, input, 1 bit: downstream takes the word this cycle.
REQ-011 SHALL have port count, output, clog2(DEPTH)+1 bits: number of stored entries.
REQ-012 SHALL have port xfer_cnt, output, 16 bits: number of completed output transfers, wrapping.

Function
REQ-013 SHALL define push as in_valid && in_ready, sampled at the rising edge.
REQ-014 SHALL define pop as out_valid && out_ready, sampled at the rising edge.
REQ-015 SHALL drive in_ready = (count != DEPTH), from registered count only, with no combinational path from out_ready.
REQ-016 SHALL drive out_valid = (count != 0), from registered count only.
REQ-017 SHALL drive out_data from the storage entry at the read pointer; its value is don't-care while out_valid=0.
REQ-018 SHALL, on push, write in_data at the write pointer and advance the write pointer modulo DEPTH.
REQ-019 SHALL, on pop, advance the read pointer modulo DEPTH.
REQ-020 SHALL give 1-cycle minimum latency: a word pushed at edge N is visible on out_valid/out_data after edge N, with no same-cycle fall-through.
REQ-021 SHALL update count as +1 on push only, -1 on pop only, and unchanged on push and pop in the same cycle or on neither.
REQ-022 SHALL, when push and pop occur in the same cycle at count 1, present the new word after the edge with count staying 1.
REQ-023 SHALL, when full, keep in_ready=0 even if out_ready=1; the push is accepted the cycle after the pop frees an entry.
REQ-024 SHALL ignore in_data while in_valid=0 and SHALL never alter storage on a rejected input.
REQ-025 SHALL preserve output order and SHALL never drop or duplicate a word.
REQ-026 SHALL keep out_data stable while out_valid=1 and out_ready=0.
REQ-027 SHALL increment xfer_cnt by 1 on every pop, wrapping from 0xFFFF to 0x0000.
REQ-028 SHALL wrap both pointers through DEPTH-1 to 0 with no bubble cycle.

Reset
REQ-029 SHALL, while rst=1 at an edge, set count=0, both pointers=0, xfer_cnt=0; thus out_valid=0 and in_ready=1 after that edge.
REQ-030 SHALL give rst priority over a simultaneous push or pop; a word pending at reset is discarded and is not counted.
REQ-031 SHALL NOT reset the storage array contents.

Verification
REQ-032 Reset mid-stream: hold 3 stored words, assert rst for 1 cycle -> count=0, out_valid=0, in_ready=1, xfer_cnt=0 on the next cycle.
REQ-033 Fill (DEPTH=4): push 0x11,0x22,0x33,0x44 with out_ready=0 -> count=4, in_ready=0, out_data=0x11; a fifth push with in_valid=1 is not accepted.
REQ-034 Full with simultaneous demand: at count=4, set out_ready=1 and in_valid=1 with 0x55 -> cycle 1 pops 0x11 and accepts no push; cycle 2 pops 0x22 and pushes 0x55; count goes 4->3->3.
REQ-035 Streaming: in_valid=1 and out_ready=1 continuously for 20 words 0x00..0x13 -> output order matches input, count stays at most 1, xfer_cnt=20.
REQ-036 Wrap: 10 push/pop cycles through DEPTH=4 with random out_ready stalls -> no loss, and out_data stays stable during every stall.
REQ-037 Counter wrap: preload by 65535 pops, then 2 more pops -> xfer_cnt reads 0xFFFF, then 0x0000, then 0x0001.
